// File: rtl/vu_sched_pkg.sv
// Shared types and sizing constants for the VU-meter source scheduler,
// kept in step with the ram_logic buffers and the VU meter.
package vu_sched_pkg;

    typedef enum logic {
        SEL_FIXED = 1'b0,
        SEL_SCAN  = 1'b1
    } sel_mode_e;

    localparam int DROP_CNT_W = 16;
    localparam int VU_N_SRC   = 4;
    localparam int VU_DATA_W  = 24;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr with wrap;
// the pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int  N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     elig_i,
    input  logic             adv_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr_q) + k) % N);
            if (elig_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = idx;
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv_i && gnt_vld_o) begin
            rr_ptr_d = (gnt_idx_o == IDX_LAST) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/vu_source_scheduler.sv
// Drains N_SRC sample buffers round-robin into one VU-meter slot; only the
// monitored channel is forwarded, everything else is dropped and counted.
module vu_source_scheduler
    import vu_sched_pkg::*;
#(
    parameter int  N_SRC        = VU_N_SRC,
    parameter int  DATA_W       = VU_DATA_W,
    parameter int  DWELL_CYCLES = 27000000,
    localparam int CH_W         = $clog2(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_SRC*DATA_W-1:0] src_data_i,
    input  logic [N_SRC-1:0]        src_valid_i,
    output logic [N_SRC-1:0]        src_ready_o,
    input  logic                    sel_mode_i,
    input  logic [CH_W-1:0]         sel_chan_i,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CH_W-1:0]         out_chan_o,
    output logic [CH_W-1:0]         active_chan_o,
    output logic                    chan_switch_o,
    output logic [DROP_CNT_W-1:0]   drop_count_o
);
    localparam int                 DWELL_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(N_SRC - 1);

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    sel_mode_e                state_q, state_d;
    logic [CH_W-1:0]          active_chan_q, active_chan_d;
    logic [DWELL_W-1:0]       dwell_q, dwell_d;
    logic                     chan_switch_q, chan_switch_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]          out_chan_q, out_chan_d;
    logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [N_SRC-1:0] elig;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             sel_in_range;

    // The active channel may only be granted when the slot can take its sample.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = rst_ni && src_valid_i[i] &&
                      ((CH_W'(i) != active_chan_q) || !out_valid_q);
        end
    end

    rr_arbiter #(.N(N_SRC)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .elig_i    (elig),
        .adv_i     (1'b1),
        .gnt_o     (src_ready_o),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        drop_cnt_d  = drop_cnt_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (gnt_vld) begin
            if (gnt_idx == active_chan_q) begin
                out_valid_d = 1'b1;
                out_data_d  = $signed(src_data_i[int'(gnt_idx)*DATA_W +: DATA_W]);
                out_chan_d  = gnt_idx;
            end else begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end
    end

    assign sel_in_range = {1'b0, sel_chan_i} < (CH_W + 1)'(N_SRC);

    // Decisions key off the incoming mode so FIXED adopts sel_chan_i on entry.
    always_comb begin
        state_d       = sel_mode_i ? SEL_SCAN : SEL_FIXED;
        active_chan_d = active_chan_q;
        dwell_d       = dwell_q;
        case (state_d)
            SEL_FIXED: begin
                dwell_d = '0;
                if (sel_in_range) begin
                    active_chan_d = sel_chan_i;
                end
            end
            SEL_SCAN: begin
                if (state_q == SEL_FIXED) begin
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d       = '0;
                    active_chan_d = (active_chan_q == CH_LAST) ? '0 : active_chan_q + CH_W'(1);
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: dwell_d = '0;
        endcase
        chan_switch_d = (active_chan_d != active_chan_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= SEL_FIXED;
            active_chan_q <= '0;
            dwell_q       <= '0;
            chan_switch_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_chan_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            active_chan_q <= active_chan_d;
            dwell_q       <= dwell_d;
            chan_switch_q <= chan_switch_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_chan_q    <= out_chan_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_chan_o    = out_chan_q;
    assign active_chan_o = active_chan_q;
    assign chan_switch_o = chan_switch_q;
    assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_vu_source_scheduler.sv
// Bench for vu_source_scheduler: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_vu_source_scheduler;
    localparam int N     = 4;
    localparam int DW    = 24;
    localparam int DWELL = 8;
    localparam int N6    = 6;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic            sel_mode;
    logic [1:0]      sel_chan;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_chan;
    logic [1:0]      active_chan;
    logic            chan_switch;
    logic [15:0]     drop_count;

    logic [N6*DW-1:0] s6_data;
    logic [N6-1:0]    s6_valid;
    logic [N6-1:0]    s6_ready;
    logic             s6_mode;
    logic [2:0]       s6_chan;
    logic [DW-1:0]    o6_data;
    logic             o6_valid;
    logic             o6_ready;
    logic [2:0]       o6_chan;
    logic [2:0]       a6_chan;
    logic             sw6;
    logic [15:0]      drop6;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vu_source_scheduler #(.N_SRC(N), .DATA_W(DW), .DWELL_CYCLES(DWELL)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .src_data_i(src_data), .src_valid_i(src_valid),
        .src_ready_o(src_ready), .sel_mode_i(sel_mode), .sel_chan_i(sel_chan),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_chan_o(out_chan), .active_chan_o(active_chan), .chan_switch_o(chan_switch),
        .drop_count_o(drop_count)
    );

    vu_source_scheduler #(.N_SRC(N6), .DATA_W(DW), .DWELL_CYCLES(DWELL)) dut6 (
        .clk_i(clk), .rst_ni(rst_ni), .src_data_i(s6_data), .src_valid_i(s6_valid),
        .src_ready_o(s6_ready), .sel_mode_i(s6_mode), .sel_chan_i(s6_chan),
        .out_data_o(o6_data), .out_valid_o(o6_valid), .out_ready_i(o6_ready),
        .out_chan_o(o6_chan), .active_chan_o(a6_chan), .chan_switch_o(sw6),
        .drop_count_o(drop6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: what the scheduler must look like after each edge.
    int          m_act, m_rr, m_dwell, m_drop, m_oc, m_g, m_old;
    bit          m_ov, m_sw, m_scan;
    logic [DW-1:0] m_od;

    function automatic int model_grant();
        if (!rst_ni) return -1;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_rr + k) % N;
            if (src_valid[s] && (s != m_act || !m_ov)) return s;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_act = 0; m_rr = 0; m_dwell = 0; m_drop = 0; m_oc = 0;
            m_ov = 0; m_sw = 0; m_scan = 0; m_od = '0;
        end else begin
            m_g   = model_grant();
            m_old = m_act;
            if (m_ov && out_ready) m_ov = 0;
            if (m_g >= 0) begin
                if (m_g == m_act) begin
                    m_ov = 1;
                    m_od = src_data[m_g*DW +: DW];
                    m_oc = m_g;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_rr = (m_g + 1) % N;
            end
            if (!sel_mode) begin
                m_scan  = 0;
                m_dwell = 0;
                if (int'(sel_chan) < N) m_act = int'(sel_chan);
            end else begin
                if (m_scan) begin
                    m_dwell++;
                    if (m_dwell == DWELL) begin
                        m_dwell = 0;
                        m_act   = (m_act + 1) % N;
                    end
                end else begin
                    m_dwell = 0;
                end
                m_scan = 1;
            end
            m_sw = (m_act != m_old);
        end
    end

    int         c_g;
    logic [N-1:0] c_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            c_g   = model_grant();
            c_rdy = (c_g >= 0) ? (N'(1) << c_g) : '0;
            check("model_src_ready", 32'(src_ready), 32'(c_rdy));
            check("model_out_valid", 32'(out_valid), 32'(m_ov));
            check("model_out_data",  32'(out_data),  32'(m_od));
            check("model_out_chan",  32'(out_chan),  32'(m_oc));
            check("model_active",    32'(active_chan), 32'(m_act));
            check("model_switch",    32'(chan_switch), 32'(m_sw));
            check("model_drops",     32'(drop_count),  32'(m_drop));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst_ni = 1'b0; src_valid = '1; sel_mode = 1'b0; sel_chan = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) src_data[i*DW +: DW] = DW'($urandom);
        s6_data = '0; s6_valid = '0; s6_mode = 1'b0; s6_chan = 3'd0; o6_ready = 1'b1;
        tick();
        chk_en = 1'b1;

        // Reset held with every source valid.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(src_ready), 32'h0);
            check("rst_outputs", {out_valid, out_chan, active_chan, chan_switch, drop_count},
                  32'h0);
            check("rst_data", 32'(out_data), 32'h0);
            tick();
        end

        // FIXED on channel 2, all sources continuous.
        rst_ni = 1'b1; src_valid = '0; sel_chan = 2'd2; out_ready = 1'b1; s6_chan = 3'd5;
        tick();
        check("n6_sel5_adopted", 32'(a6_chan), 32'd5);
        for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 24'hA00000 + DW'(i);
        src_valid = '1; s6_chan = 3'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fixed_grant_order", 32'(src_ready), 32'(4'b0001 << (i % 4)));
            if (out_valid) begin
                check("fixed_out_chan", 32'(out_chan), 32'd2);
                check("fixed_out_data", 32'(out_data), 32'hA00002);
            end
            tick();
        end
        src_valid = '0;
        @(negedge clk);
        check("fixed_drops_after_8", 32'(drop_count), 32'd6);
        check("n6_sel7_ignored", 32'(a6_chan), 32'd5);

        // Backpressure on channel 1.
        tick();
        sel_chan = 2'd1; out_ready = 1'b1;
        tick(); tick();
        src_data[1*DW +: DW] = 24'h123456; src_valid = '1; out_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (src_ready[1]) got = 1'b1;
            tick();
        end
        check("bp_first_accept", 32'(got), 32'd1);
        src_data[1*DW +: DW] = 24'h654321;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'h123456);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_src1_blocked", 32'(src_ready[1]), 32'd0);
            check("bp_others_granted", 32'(|src_ready), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk);
            if (src_ready[1]) got = 1'b1;
            tick();
        end
        check("bp_second_accept", 32'(got), 32'd1);
        @(negedge clk);
        check("bp_second_data", 32'(out_data), 32'h654321);

        // SCAN from channel 0 with an 8-cycle dwell.
        tick();
        src_valid = '0; out_ready = 1'b1; sel_chan = 2'd0;
        tick(); tick();
        sel_mode = 1'b1;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            check("scan_active", 32'(active_chan), (n >= 9) ? 32'(((n - 1) / 8) % 4) : 32'd0);
            check("scan_switch", 32'(chan_switch), 32'((n >= 9) && ((n - 1) % 8 == 0)));
            tick();
        end
        sel_mode = 1'b0; sel_chan = 2'd3;
        tick();
        check("scan_to_fixed_sel3", 32'(active_chan), 32'd3);

        // Randomized traffic, mode changes and occasional mid-transfer resets.
        for (int c = 0; c < 1500; c++) begin
            src_valid = N'($urandom);
            for (int i = 0; i < N; i++) src_data[i*DW +: DW] = DW'($urandom);
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(99) == 0) sel_mode = ~sel_mode;
            if ($urandom_range(19) == 0) sel_chan = 2'($urandom);
            rst_ni = ($urandom_range(299) != 0);
            tick();
        end

        // Drop-counter saturation from a clean reset.
        rst_ni = 1'b0; sel_mode = 1'b0; sel_chan = 2'd0; out_ready = 1'b1; src_valid = '0;
        tick();
        rst_ni = 1'b1; src_valid = 4'b1110;
        repeat (65534) @(posedge clk);
        #1;
        src_valid = '0;
        @(negedge clk);
        check("sat_preload_fffe", 32'(drop_count), 32'hFFFE);
        tick();
        src_valid = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        src_valid = '0;
        @(negedge clk);
        check("sat_reach_ffff", 32'(drop_count), 32'hFFFF);
        tick();
        src_valid = 4'b1110;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("sat_hold_ffff", 32'(drop_count), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
